// File: rtl/input_aligner.sv
// Re-frames 16-sample ADC words on a sample boundary; calibration FSM finds a loopback marker offset and latency.
// Latency: 2 clocks from adc_word_in to adc_word_out.
// Backpressure: none; every input beat is accepted and adc_valid_out follows adc_valid_in.
module input_aligner #(
    parameter int SAMPLES       = 16,
    parameter int SAMPLE_W      = 16,
    parameter int CNT_W         = 16,
    parameter int TIMEOUT_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLES*SAMPLE_W-1:0]   adc_word_in,
    input  logic                          adc_valid_in,
    input  logic                          cal_start,
    input  logic [SAMPLE_W-1:0]           cal_threshold,
    input  logic                          shift_override_en,
    input  logic [3:0]                    shift_manual,
    output logic [SAMPLES*SAMPLE_W-1:0]   adc_word_out,
    output logic                          adc_valid_out,
    output logic [3:0]                    shift_active,
    output logic                          cal_busy,
    output logic                          cal_done,
    output logic                          cal_timeout,
    output logic [CNT_W-1:0]              latency_words
);

    localparam int WORD_W = SAMPLES * SAMPLE_W;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE, TIMEOUT} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   cur_q, cur_d;
    logic [WORD_W-1:0]   prev_q, prev_d;
    logic [WORD_W-1:0]   word_out_q, word_out_d;
    logic                valid_d1_q, valid_d1_d;
    logic                valid_out_q, valid_out_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    latency_q, latency_d;
    logic [SAMPLE_W-1:0] thr_q, thr_d;
    logic [3:0]          cal_shift_q, cal_shift_d;
    logic                hit;
    logic [3:0]          hit_idx;
    logic [2*WORD_W-1:0] window;

    assign shift_active  = shift_override_en ? shift_manual : cal_shift_q;
    assign window        = {cur_q, prev_q};
    assign adc_word_out  = word_out_q;
    assign adc_valid_out = valid_out_q;
    assign latency_words = latency_q;
    assign cal_busy      = (state_q == SEARCH);
    assign cal_done      = (state_q == DONE);
    assign cal_timeout   = (state_q == TIMEOUT);

    always_comb begin
        cur_d       = cur_q;
        prev_d      = prev_q;
        valid_d1_d  = adc_valid_in;
        valid_out_d = valid_d1_q;
        if (adc_valid_in) begin
            prev_d = cur_q;
            cur_d  = adc_word_in;
        end
        // prev holds the earlier samples, so shift s starts s samples into prev
        word_out_d = window[SAMPLE_W*shift_active +: WORD_W];
    end

    // Scan from the top so the lowest over-threshold index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        for (int i = SAMPLES - 1; i >= 0; i--) begin
            if ($signed(adc_word_in[i*SAMPLE_W +: SAMPLE_W]) > $signed(thr_q)) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        thr_d       = thr_q;
        cal_shift_d = cal_shift_q;
        latency_d   = latency_q;
        if (cal_start) begin
            state_d = SEARCH;
            count_d = '0;
            thr_d   = cal_threshold;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (adc_valid_in) begin
                        if (hit) begin
                            cal_shift_d = hit_idx;
                            latency_d   = count_q;
                            state_d     = DONE;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                            if (count_q == CNT_W'(TIMEOUT_WORDS - 1)) begin
                                state_d = TIMEOUT;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            prev_q      <= '0;
            word_out_q  <= '0;
            valid_d1_q  <= 1'b0;
            valid_out_q <= 1'b0;
            count_q     <= '0;
            latency_q   <= '0;
            thr_q       <= '0;
            cal_shift_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            word_out_q  <= word_out_d;
            valid_d1_q  <= valid_d1_d;
            valid_out_q <= valid_out_d;
            count_q     <= count_d;
            latency_q   <= latency_d;
            thr_q       <= thr_d;
            cal_shift_q <= cal_shift_d;
        end
    end

endmodule

// File: tb/tb_input_aligner.sv
// Scoreboard bench for input_aligner: a sample-stream reference model predicts aligned words and calibration results.
module tb_input_aligner;

    localparam int TW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] adc_word_in;
    logic         adc_valid_in;
    logic         cal_start;
    logic [15:0]  cal_threshold;
    logic         shift_override_en;
    logic [3:0]   shift_manual;
    logic [255:0] adc_word_out;
    logic         adc_valid_out;
    logic [3:0]   shift_active;
    logic         cal_busy;
    logic         cal_done;
    logic         cal_timeout;
    logic [15:0]  latency_words;

    always #5 clk = ~clk;

    input_aligner #(.TIMEOUT_WORDS(TW)) dut (
        .clk               (clk),
        .rst               (rst),
        .adc_word_in       (adc_word_in),
        .adc_valid_in      (adc_valid_in),
        .cal_start         (cal_start),
        .cal_threshold     (cal_threshold),
        .shift_override_en (shift_override_en),
        .shift_manual      (shift_manual),
        .adc_word_out      (adc_word_out),
        .adc_valid_out     (adc_valid_out),
        .shift_active      (shift_active),
        .cal_busy          (cal_busy),
        .cal_done          (cal_done),
        .cal_timeout       (cal_timeout),
        .latency_words     (latency_words)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] exp_q[$];

    // Reference model: whole sample history plus calibration results
    typedef enum {M_IDLE, M_SEARCH, M_DONE, M_TIMEOUT} mstate_t;
    mstate_t     m_state;
    int          m_count, m_thr, m_shift, m_lat;
    logic [15:0] hist[$];
    bit          pend;
    int          pend_n;
    int          beats;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        hist.delete();
        for (int k = 0; k < 16; k++) hist.push_back(16'h0);
        pend    = 0;
        pend_n  = 0;
        beats   = 0;
        m_state = M_IDLE;
        m_count = 0;
        m_thr   = 0;
        m_shift = 0;
        m_lat   = 0;
    endfunction

    // Output for beat n is 16 consecutive stream samples starting s into the previous word
    function automatic logic [255:0] expected_word(input int n, input int s);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = hist[16*n + s + k];
        return w;
    endfunction

    function automatic logic [255:0] ramp_word(input int base);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(base + k);
        return w;
    endfunction

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(int'($urandom_range(0, 600)) - 300);
        if ($urandom_range(0, 19) == 0) w[16*$urandom_range(0, 15) +: 16] = 16'(1000 + $urandom_range(0, 5000));
        return w;
    endfunction

    // One clock: apply inputs, advance the model, then check status after the edge
    task automatic drive(input bit v, input logic [255:0] w, input bit cs, input int thr,
                         input bit ov, input int man);
        int idx;
        int samp;
        adc_valid_in      = v;
        adc_word_in       = w;
        cal_start         = cs;
        cal_threshold     = 16'(thr);
        shift_override_en = ov;
        shift_manual      = 4'(man);
        if (pend) begin
            exp_q.push_back(expected_word(pend_n, ov ? man : m_shift));
            pend = 0;
        end
        if (v) begin
            for (int k = 0; k < 16; k++) hist.push_back(w[16*k +: 16]);
            pend   = 1;
            pend_n = beats;
            beats++;
        end
        if (cs) begin
            m_state = M_SEARCH;
            m_count = 0;
            m_thr   = int'($signed(16'(thr)));
        end else if (m_state == M_SEARCH && v) begin
            idx = -1;
            for (int k = 0; k < 16; k++) begin
                samp = int'($signed(w[16*k +: 16]));
                if (idx < 0 && samp > m_thr) idx = k;
            end
            if (idx >= 0) begin
                m_shift = idx;
                m_lat   = m_count;
                m_state = M_DONE;
            end else begin
                if (m_count == TW - 1) m_state = M_TIMEOUT;
                m_count++;
            end
        end
        @(posedge clk);
        #1;
        check("cal_busy", cal_busy, m_state == M_SEARCH);
        check("cal_done", cal_done, m_state == M_DONE);
        check("cal_timeout", cal_timeout, m_state == M_TIMEOUT);
        check("latency_words", latency_words, m_lat);
        check("shift_active", shift_active, ov ? man : m_shift);
    endtask

    task automatic reset_mid();
        shift_override_en = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst adc_word_out", adc_word_out, 0);
        check("rst adc_valid_out", adc_valid_out, 0);
        check("rst shift_active", shift_active, 0);
        check("rst latency_words", latency_words, 0);
        check("rst cal_busy", cal_busy, 0);
        check("rst cal_done", cal_done, 0);
        check("rst cal_timeout", cal_timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && adc_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected output beat: got %h expected no beat", adc_word_out);
            end else begin
                check("aligned word", adc_word_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w;
        int ramp;
        int nv;
        bit v;

        rst               = 1'b0;
        adc_word_in       = '0;
        adc_valid_in      = 1'b0;
        cal_start         = 1'b0;
        cal_threshold     = '0;
        shift_override_en = 1'b0;
        shift_manual      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init adc_word_out", adc_word_out, 0);
        check("init adc_valid_out", adc_valid_out, 0);
        check("init cal_busy", cal_busy, 0);
        rst = 1'b1;

        // Constant 0x0001 stream interrupted by an asynchronous reset
        for (int i = 0; i < 4; i++) drive(1, {16{16'h0001}}, 0, 0, 0, 0);
        reset_mid();
        drive(1, {16{16'h0001}}, 0, 0, 0, 0);
        check("valid_out after 1 clk", adc_valid_out, 0);
        drive(0, '0, 0, 0, 0, 0);
        check("valid_out after 2 clk", adc_valid_out, 1);
        drive(0, '0, 0, 0, 0, 0);

        // Ramp stream with manual shift swept over every value
        ramp = 0;
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 6; i++) begin
                v = (i != 2);
                drive(v, ramp_word(ramp), 0, 0, 1, s);
                if (v) ramp += 16;
            end
        end

        // Single marker at index 7 of the sixth search beat
        drive(0, '0, 1, 1000, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, '0, 0, 1000, 0, 0);
        w = '0;
        w[16*7 +: 16] = 16'd2000;
        drive(1, w, 0, 1000, 0, 0);
        check("marker cal_done", cal_done, 1);
        check("marker shift", shift_active, 7);
        check("marker latency", latency_words, 5);
        drive(1, '0, 0, 1000, 0, 0);
        drive(0, '0, 0, 1000, 0, 0);

        // Equal-to-threshold ignored; lowest of two hits chosen
        drive(1, '0, 1, 1000, 0, 0);
        w = '0;
        w[0 +: 16] = 16'd1000;
        drive(1, w, 0, 1000, 0, 0);
        drive(1, '0, 0, 1000, 0, 0);
        w = '0;
        w[16*1 +: 16] = 16'd1000;
        w[16*3 +: 16] = 16'd1500;
        w[16*9 +: 16] = 16'd3000;
        drive(1, w, 0, 1000, 0, 0);
        check("two hits shift", shift_active, 3);
        check("two hits latency", latency_words, 2);

        // Timeout with gaps in the valid stream
        drive(0, '0, 1, 1000, 0, 0);
        nv = 0;
        for (int i = 0; i < 20 && nv < TW; i++) begin
            v = (i % 3 != 1);
            drive(v, '0, 0, 1000, 0, 0);
            if (v) nv++;
            if (v && nv == TW - 1) check("busy before timeout", cal_busy, 1);
        end
        check("timeout flag", cal_timeout, 1);
        check("timeout keeps shift", shift_active, 3);
        check("timeout keeps latency", latency_words, 2);

        // Restart on the marker cycle, then marker three beats later
        drive(1, '0, 1, 1000, 0, 0);
        drive(1, '0, 0, 1000, 0, 0);
        w = '0;
        w[16*5 +: 16] = 16'd2000;
        drive(1, w, 1, 1000, 0, 0);
        check("restart still busy", cal_busy, 1);
        check("restart not done", cal_done, 0);
        drive(1, '0, 0, 1000, 0, 0);
        drive(0, '0, 0, 1000, 0, 0);
        drive(1, '0, 0, 1000, 0, 0);
        drive(1, '0, 0, 1000, 0, 0);
        w = '0;
        w[16*11 +: 16] = 16'd2000;
        drive(1, w, 0, 1000, 0, 0);
        check("restart latency", latency_words, 3);
        check("restart shift", shift_active, 11);

        // Reset with non-zero calibration results mid-stream
        drive(1, rand_word(), 0, 1000, 0, 0);
        drive(1, rand_word(), 0, 1000, 0, 0);
        reset_mid();

        // Random traffic, calibration restarts and overrides
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 24) == 0,
                  int'($urandom_range(200, 900)), $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 0, 0);
        check("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_aligner.md
Name: input_aligner

Overview:
- Receive-side counterpart to the DAC output shifter: takes 256-bit ADC words (16 x 16-bit samples per clock) and re-frames them on an arbitrary sample boundary.
- Has a calibration FSM that detects a loopback marker pulse, then records its sample offset (0..15) and its round-trip latency in words.
- Sits between the ADC AXI-stream capture and the Ising-machine measurement/feedback logic.

Parameters:
- SAMPLES, 16, samples per word (fixed; the design assumes 16).
- SAMPLE_W, 16, bits per sample, signed two's complement.
- CNT_W, 16, width of the latency/timeout word counter.
- TIMEOUT_WORDS, 1024, valid beats searched before giving up; range 2..2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- adc_word_in  in  256  sample i = bits [16i+15:16i]; sample 0 is earliest in time
- adc_valid_in  in  1  qualifies adc_word_in
- cal_start  in  1  single-cycle pulse; starts or restarts calibration
- cal_threshold  in  16  signed marker threshold, captured on cal_start
- shift_override_en  in  1  1 = use shift_manual instead of the calibrated shift
- shift_manual  in  4  manual sample shift
- adc_word_out  out  256  aligned word
- adc_valid_out  out  1  qualifies adc_word_out
- shift_active  out  4  shift currently applied
- cal_busy  out  1  high in SEARCH
- cal_done  out  1  high in DONE
- cal_timeout  out  1  high in TIMEOUT
- latency_words  out  CNT_W  count of valid beats from the first SEARCH beat to the marker beat

Behaviour:
- Reset (rst low, async):
  - all registers and outputs are 0, including adc_word_out, adc_valid_out, shift_active, latency_words and the calibrated shift.
  - FSM goes to IDLE; any calibration in progress is abandoned.
- Datapath:
  - On each clk with adc_valid_in=1: prev <= cur, cur <= adc_word_in. If adc_valid_in=0, cur and prev hold.
  - Window W = {cur, prev} (512 bits). Every clock: adc_word_out <= W[16*s +: 256], where s = shift_active. adc_valid_out <= registered adc_valid_in.
  - Latency: 2 clocks from adc_word_in to adc_word_out. With input words N-1, N, output = samples 16(N-1)+s .. 16N+s-1 of the stream; s=0 outputs word N-1 unmodified.
  - shift_active = shift_override_en ? shift_manual : cal_shift (combinational mux of registered sources). A change takes effect on the next output register update. Valid beats in flight are not re-timed.
- FSM states: IDLE, SEARCH, DONE, TIMEOUT.
  - IDLE/DONE/TIMEOUT + cal_start -> SEARCH. On entry: count <= 0, thr <= cal_threshold.
  - SEARCH, valid beat, any sample in adc_word_in with signed value > thr:
    - marker index i = lowest such sample index.
    - cal_shift <= i, latency_words <= count, go to DONE.
  - SEARCH, valid beat, no hit: count <= count+1. If count == TIMEOUT_WORDS-1, go to TIMEOUT; cal_shift and latency_words are unchanged.
  - SEARCH, invalid beat: no change.
  - cal_start while in SEARCH restarts the search: count cleared, thr recaptured. The current beat is not evaluated.
  - cal_start takes priority over a hit in the same cycle.
  - Comparison is on the raw adc_word_in, not on the aligned output. Equal to threshold is not a hit.
  - cal_shift and latency_words persist across TIMEOUT and a later SEARCH until a new hit is found.
- Status outputs are decoded from the state register (registered) and are mutually exclusive. All are 0 in IDLE.
- shift_override_en does not affect the FSM; calibration runs normally while override is active.

Test Plan:
- Reset with constant input 0x0001 in every sample, then assert rst low mid-stream -> all outputs 0 the same cycle, state IDLE. After release, adc_valid_out follows adc_valid_in with 2-clock delay.
- Ramp stream (sample value = global sample index), shift_manual=0..15 swept with override -> first sample of each output word = 16(N-1)+s for every s, including s=15.
- cal_threshold=1000, ramp of zeros with a single 2000 at stream sample 16*5+7 (5th word after the SEARCH entry word, index 7) -> cal_done, shift_active=7, latency_words=5. Aligned output word then starts with the marker.
- Two samples over threshold in the same word (indices 3 and 9) -> cal_shift=3. A sample exactly equal to the threshold is ignored.
- TIMEOUT_WORDS=8, no marker -> cal_timeout after the 8th valid beat. Prior cal_shift/latency are retained. Gaps in adc_valid_in do not advance count.
- cal_start re-pulsed during SEARCH on the cycle a marker arrives -> no DONE, count restarts at 0. A marker 3 valid beats later gives latency_words=3.
